// File: rtl/shift_add_multiplier_pkg.sv
// Package mult_pkg: shared FSM state encoding for the shift-and-add
// multiplier. Imported by the control FSM and by the testbench.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/result bus of the shift-and-add multiplier.
//   St      master->slave  start request (only honoured while Idle=1)
//   Mcand   master->slave  multiplicand, WIDTH bits
//   Mplier  master->slave  multiplier, WIDTH bits
//   Product slave->master  2*WIDTH-bit result, valid while Done=1
//   Idle    slave->master  unit can accept St
//   Done    slave->master  one-cycle completion pulse
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 St;
  logic [WIDTH-1:0]     Mcand;
  logic [WIDTH-1:0]     Mplier;
  logic [2*WIDTH-1:0]   Product;
  logic                 Idle;
  logic                 Done;

  modport master (output St, Mcand, Mplier, input Product, Idle, Done);
  modport slave  (input St, Mcand, Mplier, output Product, Idle, Done);
endinterface

// File: rtl/shift_add_multiplier_control.sv
// mult_control: sequencing FSM of the shift-and-add multiplier.
// Ports:
//   Clk, Rst   clock, synchronous active-high reset
//   St         start request, sampled in S_IDLE only
//   M          current multiplier LSB (ACC[0])
//   K          last iteration flag (count == WIDTH-1)
//   Idle, Done status outputs
//   Load/Ad/Sh combinational datapath strobes: load operands, add, shift
module mult_control
  import mult_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  input  logic K,
  output logic Idle,
  output logic Done,
  output logic Load,
  output logic Ad,
  output logic Sh
);

  state_t state_q, state_d;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    Idle    = 1'b0;
    Done    = 1'b0;
    Load    = 1'b0;
    Ad      = 1'b0;
    Sh      = 1'b0;
    case (state_q)
      S_IDLE: begin
        Idle = 1'b1;
        if (St) begin
          Load    = 1'b1;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        // Add only when the current multiplier bit is set.
        Ad      = M;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        Sh      = 1'b1;
        state_d = K ? S_DONE : S_ADD;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier, one multiplier
// bit per add/shift pair; Done pulses 2*WIDTH cycles after the start edge.
// Ports:
//   Clk  clock (rising edge)
//   Rst  synchronous active-high reset
//   bus  shift_add_multiplier_if.slave: St, Mcand, Mplier in; Product, Idle, Done out
// Build option: define SIGNED_MODE_EN for two's-complement operation
// (sign-extended add, arithmetic shift, subtract on the multiplier sign bit).
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  shift_add_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  // ACC holds {carry, upper field, multiplier}; the multiplier bits are
  // consumed from the LSB as the partial product shifts in from the top.
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic m, k, load, ad, sh;
  logic [WIDTH:0] upper, addend, upper_sum;

  assign m = acc_q[0];
  assign k = (count_q == CNT_W'(WIDTH - 1));

  mult_control u_ctrl (
    .Clk  (Clk),
    .Rst  (Rst),
    .St   (bus.St),
    .M    (m),
    .K    (k),
    .Idle (bus.Idle),
    .Done (bus.Done),
    .Load (load),
    .Ad   (ad),
    .Sh   (sh)
  );

  assign upper = acc_q[2*WIDTH:WIDTH];

`ifdef SIGNED_MODE_EN
  // Sign bit of the multiplier weighs -2^(WIDTH-1): subtract on the last add.
  assign addend    = {mcand_q[WIDTH-1], mcand_q};
  assign upper_sum = k ? (upper - addend) : (upper + addend);
`else
  assign addend    = {1'b0, mcand_q};
  assign upper_sum = upper + addend;
`endif

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    count_d = count_q;
    if (load) begin
      acc_d   = {{(WIDTH+1){1'b0}}, bus.Mplier};
      mcand_d = bus.Mcand;
      count_d = '0;
    end else if (ad) begin
      acc_d[2*WIDTH:WIDTH] = upper_sum;
    end else if (sh) begin
`ifdef SIGNED_MODE_EN
      acc_d = {acc_q[2*WIDTH], acc_q[2*WIDTH:1]};
`else
      acc_d = {1'b0, acc_q[2*WIDTH:1]};
`endif
      if (!k) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  assign bus.Product = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: WIDTH=8 instance for the vector
// table and multi-cycle sequences, plus a WIDTH=4 instance.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  shift_add_multiplier_if #(.WIDTH(8)) bus8 ();
  shift_add_multiplier_if #(.WIDTH(4)) bus4 ();

  shift_add_multiplier #(.WIDTH(8)) dut8 (.Clk(Clk), .Rst(Rst), .bus(bus8));
  shift_add_multiplier #(.WIDTH(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef SIGNED_MODE_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
`else
    return 16'(int'(a) * int'(b));
`endif
  endfunction

  // One full op on the 8-bit unit: checks acceptance, 16-cycle latency,
  // result, one-cycle Done, and that a mid-op St plus operand changes are ignored.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    @(negedge Clk);
    bus8.St = 1'b1; bus8.Mcand = a; bus8.Mplier = b;
    chk({nm, " idle"}, 32'(bus8.Idle), 32'd1);
    @(posedge Clk); #1;
    bus8.St = 1'b0; bus8.Mcand = ~a; bus8.Mplier = ~b;
    n = 0;
    while (n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (n == 3) bus8.St = 1'b1;
      if (n == 5) bus8.St = 1'b0;
      if (bus8.Done) break;
    end
    chk({nm, " latency"}, 32'(n), 32'd16);
    chk({nm, " product"}, 32'(bus8.Product), 32'(exp));
    @(posedge Clk); #1;
    chk({nm, " done width"}, 32'(bus8.Done), 32'd0);
    chk({nm, " back idle"}, 32'(bus8.Idle), 32'd1);
  endtask

  initial begin
    logic [7:0] la[0:2];
    logic [7:0] lb[0:2];
    int n;

    tbl[0] = '{"13x11",   8'd13,  8'd11,  16'h008F};
    tbl[1] = '{"255x255", 8'hFF,  8'hFF,  16'hFE01};
    tbl[2] = '{"0x200",   8'd0,   8'd200, 16'h0000};
    tbl[3] = '{"200x0",   8'd200, 8'd0,   16'h0000};
`ifdef SIGNED_MODE_EN
    tbl[4] = '{"m3x5",     8'hFD, 8'h05, 16'hFFF1};
    tbl[5] = '{"m128xm128",8'h80, 8'h80, 16'h4000};
    tbl[6] = '{"127xm1",   8'h7F, 8'hFF, 16'hFF81};
    tbl[7] = '{"m1x1",     8'hFF, 8'h01, 16'hFFFF};
`else
    tbl[4] = '{"FDx05",   8'hFD, 8'h05, 16'h04F1};
    tbl[5] = '{"80x80",   8'h80, 8'h80, 16'h4000};
    tbl[6] = '{"7FxFF",   8'h7F, 8'hFF, 16'h7E81};
    tbl[7] = '{"FFx01",   8'hFF, 8'h01, 16'h00FF};
`endif

    Rst = 1'b1;
    bus8.St = 1'b0; bus8.Mcand = '0; bus8.Mplier = '0;
    bus4.St = 1'b0; bus4.Mcand = '0; bus4.Mplier = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset idle", 32'(bus8.Idle), 32'd1);
    chk("reset done", 32'(bus8.Done), 32'd0);
    chk("reset product", 32'(bus8.Product), 32'd0);
    chk("reset product w4", 32'(bus4.Product), 32'd0);
    Rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].p);

    // Abort an op with reset 5 cycles in.
    @(negedge Clk);
    bus8.St = 1'b1; bus8.Mcand = 8'd13; bus8.Mplier = 8'd11;
    @(posedge Clk); #1;
    bus8.St = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("abort idle", 32'(bus8.Idle), 32'd1);
    chk("abort product", 32'(bus8.Product), 32'd0);
    chk("abort done", 32'(bus8.Done), 32'd0);
    n = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (bus8.Done) n++;
    end
    chk("abort no done", 32'(n), 32'd0);
    run_op("7x6 after abort", 8'd7, 8'd6, 16'h002A);

    // St held high with operands changing every cycle. A load edge is
    // followed by 16 add/shift edges, one edge into DONE->IDLE, and the
    // next load edge, so loads fall on edges 0, 18, 36.
    for (int e = 0; e < 54; e++) begin
      @(negedge Clk);
      bus8.St = 1'b1;
      bus8.Mcand = 8'(e * 37 + 5);
      bus8.Mplier = 8'(e * 91 + 3);
      if (e % 18 == 0) begin
        la[e / 18] = bus8.Mcand;
        lb[e / 18] = bus8.Mplier;
      end
      @(posedge Clk); #1;
      if (e % 18 == 16) begin
        chk("held done", 32'(bus8.Done), 32'd1);
        chk("held product", 32'(bus8.Product), 32'(ref_mul(la[e / 18], lb[e / 18])));
      end else begin
        chk("held no done", 32'(bus8.Done), 32'd0);
      end
    end
    @(negedge Clk);
    bus8.St = 1'b0;
    @(posedge Clk); #1;
    chk("held stop idle", 32'(bus8.Idle), 32'd1);

    // WIDTH=4 instance: 15 * 15, Done 8 cycles after the start edge.
    @(negedge Clk);
    bus4.St = 1'b1; bus4.Mcand = 4'hF; bus4.Mplier = 4'hF;
    @(posedge Clk); #1;
    bus4.St = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge Clk); #1;
      n++;
      if (bus4.Done) break;
    end
    chk("w4 latency", 32'(n), 32'd8);
`ifdef SIGNED_MODE_EN
    chk("w4 product", 32'(bus4.Product), 32'h01);
`else
    chk("w4 product", 32'(bus4.Product), 32'hE1);
`endif
    @(posedge Clk); #1;
    chk("w4 done width", 32'(bus4.Done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
